aes_sbox_pipe: RTL and testbench

Multi-lane AES byte-substitution unit with a configurable pipeline depth and per-transaction forward or inverse mode.
It is the successor to the single-byte combinational S-box ROM and serves SubBytes and InvSubBytes in the round datapath, plus SubWord in key expansion.
Each accepted transaction substitutes LANES bytes in parallel.
Transactions flow through a valid/ready pipeline that collapses bubbles.

---
 rtl/aes_sbox_pipe.sv | 185 ++++++++++++++++++
 tb/tb_aes_sbox_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_pipe.sv
// -----------------------------------------------------------------------------
// aes_sbox_pipe
//
// Multi-lane AES byte-substitution unit. Each accepted transaction carries
// LANES bytes plus a mode bit; every byte goes through its own forward or
// inverse S-box, and the result enters a STAGES-deep valid/ready pipeline.
// The pipeline collapses bubbles, so an empty stage is refilled even while the
// output is stalled.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high (v_i & ready_o at the input, v_o & ready_i at the output).
// A producer must hold its valid, data and mode stable until the transfer;
// ready never depends on the same side's valid, so there is no loop.
//
// Parameters
//   LANES   bytes substituted in parallel per transaction (1..16)
//   STAGES  register stages between acceptance and output (>=1)
//
// Ports
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   v_i        input transaction valid
//   ready_o    unit accepts a transaction this cycle
//   inv_i      0 = forward S-box, 1 = inverse S-box (sampled with data_i)
//   data_i     input bytes, lane k in bits [8k+7:8k]
//   v_o        output transaction valid
//   ready_i    downstream accepts the output this cycle
//   data_o     substituted bytes, same lane mapping as data_i
//   inv_o      mode bit travelling with the transaction
//   busy_o     at least one stage holds a valid transaction
// -----------------------------------------------------------------------------
module aes_sbox_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic               inv_i,
    input  logic [8*LANES-1:0] data_i,
    output logic               v_o,
    input  logic               ready_i,
    output logic [8*LANES-1:0] data_o,
    output logic               inv_o,
    output logic               busy_o
);

    localparam int W = 8 * LANES;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, AES polynomial x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128.
    // Zero maps to zero, which is what the S-box definition needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Rotate left by n (1..7): the top byte of the doubled word after shifting.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // Forward S-box: inverse followed by the affine transform (constant 0x63).
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform (constant 0x05) then inverse.
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] y;
        y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

    // ------------------------------------------------------------------
    // Per-lane substitution of the incoming bytes (feeds stage 1 only)
    // ------------------------------------------------------------------
    logic [W-1:0] sub_data;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] fwd_b;
        logic [7:0] inv_b;
        assign fwd_b = sbox_fwd(data_i[8*k +: 8]);
        assign inv_b = sbox_inv(data_i[8*k +: 8]);
        assign sub_data[8*k +: 8] = inv_i ? inv_b : fwd_b;
    end

    // ------------------------------------------------------------------
    // Pipeline state; index 0 is the input stage, STAGES-1 the output stage
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] m_q, m_d;
    logic [W-1:0]      d_q [STAGES];
    logic [W-1:0]      d_d [STAGES];
    logic [STAGES-1:0] adv;
    logic              accept;

    // A stage may advance when the stage after it is empty or advancing.
    // Computed from the output end backwards, so a full pipe with ready_i=1
    // still accepts a new transaction in the same cycle.
    always_comb begin
        adv[STAGES-1] = ~v_q[STAGES-1] | ready_i;
        for (int s = STAGES - 2; s >= 0; s--) begin
            adv[s] = ~v_q[s+1] | adv[s+1];
        end
    end

    assign ready_o = adv[0];
    assign accept  = v_i & adv[0];

    // Next state: registers hold unless their stage advances, and data/mode
    // only load from a valid source to avoid needless toggling.
    always_comb begin
        v_d = v_q;
        m_d = m_q;
        d_d = d_q;
        if (adv[0]) begin
            v_d[0] = accept;
            if (accept) begin
                d_d[0] = sub_data;
                m_d[0] = inv_i;
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            if (adv[s]) begin
                v_d[s] = v_q[s-1];
                if (v_q[s-1]) begin
                    d_d[s] = d_q[s-1];
                    m_d[s] = m_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q <= '0;
            m_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d_q[s] <= '0;
            end
        end else begin
            v_q <= v_d;
            m_q <= m_d;
            d_q <= d_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign v_o    = v_q[STAGES-1];
    assign data_o = d_q[STAGES-1];
    assign inv_o  = m_q[STAGES-1];
    assign busy_o = |v_q;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// -----------------------------------------------------------------------------
// tb_aes_sbox_pipe
//
// Directed bench for aes_sbox_pipe (LANES=4, STAGES=2). Expected results come
// from the FIPS-197 forward table held here; the inverse table is derived by
// inverting it. A negedge monitor pops the expected queue on every output
// handshake and checks held outputs stay stable while stalled.
// -----------------------------------------------------------------------------
module tb_aes_sbox_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int W      = 8 * LANES;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         v_i;
    logic         ready_o;
    logic         inv_i;
    logic [W-1:0] data_i;
    logic         v_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         inv_o;
    logic         busy_o;

    always #5 clk_i = ~clk_i;

    aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .inv_i     (inv_i),
        .data_i    (data_i),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .inv_o     (inv_o),
        .busy_o    (busy_o)
    );

    // ------------------------------------------------------------------
    // Reference tables
    // ------------------------------------------------------------------
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] isbox [256];

    function automatic logic [W-1:0] model(input logic inv, input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[8*k +: 8] = inv ? isbox[d[8*k +: 8]] : SBOX[d[8*k +: 8]];
        end
        return r;
    endfunction

    // Lane k carries b+k so every lane sweeps all 256 values.
    function automatic logic [W-1:0] lanes_of(input logic [7:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[8*k +: 8] = b + 8'(k);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard state and checker
    // ------------------------------------------------------------------
    logic [W:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         first_pop = 0;
    int         last_pop = 0;
    int         stall_cnt = 0;
    logic       hold_pend = 1'b0;
    logic [W+1:0] hold_val = '0;
    logic [W:0] mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_stable", 64'({v_o, inv_o, data_o}), 64'(hold_val));
            end
            hold_pend = v_o && !ready_i;
            hold_val  = {v_o, inv_o, data_o};
            if (v_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(v_o), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out", 64'({inv_o, data_o}), 64'(mon_e));
                    pop_cnt++;
                    if (pop_cnt == 1) first_pop = cyc;
                    last_pop = cyc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic inv, input logic [W-1:0] d, input logic [W-1:0] exp);
        int waited;
        waited = 0;
        v_i    = 1'b1;
        inv_i  = inv;
        data_i = d;
        @(negedge clk_i);
        while (!ready_o && waited < 50) begin
            stall_cnt++;
            waited++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            check("send_timeout", 64'(ready_o), 64'd1);
        end else begin
            exp_q.push_back({inv, exp});
        end
        tick();
        v_i    = 1'b0;
        inv_i  = 1'($urandom_range(0, 1));
        data_i = W'($urandom);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            tick();
            waited++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Call right after send(): counts edges from the accepting edge.
    task automatic lat_check(input logic [W-1:0] exp);
        for (int c = 1; c < STAGES; c++) begin
            check("lat_low", 64'(v_o), 64'd0);
            tick();
        end
        check("lat_high", 64'(v_o), 64'd1);
        check("lat_data", 64'(data_o), 64'(exp));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] a, b, c, d;
        for (int i = 0; i < 256; i++) begin
            isbox[SBOX[i]] = 8'(i);
        end

        reset_n_i = 1'b0;
        v_i       = 1'b0;
        inv_i     = 1'b0;
        data_i    = '0;
        ready_i   = 1'b0;
        tick();
        tick();
        check("rst_v_o", 64'(v_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_inv_o", 64'(inv_o), 64'd0);
        check("rst_busy_o", 64'(busy_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        reset_n_i = 1'b1;
        ready_i   = 1'b1;
        tick();
        check("post_rst_ready", 64'(ready_o), 64'd1);

        // Forward vector with latency check, then inverse vector.
        send(1'b0, 32'h0001_53FF, 32'h637C_ED16);
        lat_check(32'h637C_ED16);
        check("fwd_inv_o", 64'(inv_o), 64'd0);
        drain();
        send(1'b1, 32'h637C_ED00, 32'h0001_5352);
        drain();

        // All bytes in both modes, mode alternating every transaction.
        pop_cnt = 0;
        for (int j = 0; j < 512; j++) begin
            d = lanes_of(8'(j >> 1));
            send(1'(j), d, model(1'(j), d));
        end
        drain();
        check("stream_cnt", 64'(pop_cnt), 64'd512);
        check("stream_gap", 64'(last_pop - first_pop), 64'd511);

        // Round trip: forward results fed back as inverse inputs.
        for (int j = 0; j < 256; j++) begin
            d = lanes_of(8'(j));
            send(1'b1, model(1'b0, d), d);
        end
        drain();

        // Backpressure: A and B fill the pipe, C waits.
        ready_i = 1'b0;
        pop_cnt = 0;
        a = W'($urandom);
        b = W'($urandom);
        c = W'($urandom);
        send(1'b0, a, model(1'b0, a));
        send(1'b1, b, model(1'b1, b));
        v_i    = 1'b1;
        inv_i  = 1'b0;
        data_i = c;
        @(negedge clk_i);
        check("bp_ready_low", 64'(ready_o), 64'd0);
        check("bp_v_o", 64'(v_o), 64'd1);
        check("bp_data_a", 64'(data_o), 64'(model(1'b0, a)));
        check("bp_busy", 64'(busy_o), 64'd1);
        tick();
        @(negedge clk_i);
        check("bp_ready_low2", 64'(ready_o), 64'd0);
        check("bp_data_a2", 64'(data_o), 64'(model(1'b0, a)));
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_ready_c", 64'(ready_o), 64'd1);
        exp_q.push_back({1'b0, model(1'b0, c)});
        tick();
        v_i = 1'b0;
        drain();
        check("bp_cnt", 64'(pop_cnt), 64'd3);
        check("bp_gap", 64'(last_pop - first_pop), 64'd2);

        // Full pipe with continuous stream and ready_i held high.
        ready_i = 1'b0;
        pop_cnt = 0;
        for (int j = 0; j < STAGES; j++) begin
            d = W'($urandom);
            send(1'(j), d, model(1'(j), d));
        end
        ready_i   = 1'b1;
        stall_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            d = W'($urandom);
            send(1'($urandom_range(0, 1)) ^ 1'b0, d, 'x);
            exp_q[exp_q.size()-1] = {exp_q[exp_q.size()-1][W], model(exp_q[exp_q.size()-1][W], d)};
        end
        drain();
        check("full_stalls", 64'(stall_cnt), 64'd0);
        check("full_cnt", 64'(pop_cnt), 64'(STAGES + 20));
        check("full_gap", 64'(last_pop - first_pop), 64'(STAGES + 19));

        // Reset while two transactions are in flight.
        ready_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            d = W'($urandom);
            send(1'b0, d, model(1'b0, d));
        end
        #1 reset_n_i = 1'b0;
        #2;
        check("mid_rst_v_o", 64'(v_o), 64'd0);
        check("mid_rst_data_o", 64'(data_o), 64'd0);
        check("mid_rst_inv_o", 64'(inv_o), 64'd0);
        check("mid_rst_busy_o", 64'(busy_o), 64'd0);
        check("mid_rst_ready_o", 64'(ready_o), 64'd1);
        exp_q.delete();
        #3 reset_n_i = 1'b1;
        ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("post_rst_idle_v", 64'(v_o), 64'd0);
            check("post_rst_idle_busy", 64'(busy_o), 64'd0);
        end
        send(1'b0, 32'h5353_5353, 32'hEDED_EDED);
        lat_check(32'hEDED_EDED);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a hang if the DUT stops handshaking.
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
